// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (UDIV/SDIV), one quotient bit per clock.
// Optional build macro DIV_EARLY_OUT_EN: skip iterations when |divisor| > |dividend|.
module seq_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q;
    logic             busy_q, done_q, dbz_q, dbz_pend_q, q_neg_q, r_neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, prem_q, dsr_q, quot_q, rem_q;

    logic             dvd_neg, dsr_neg, skip_run;
    logic [WIDTH-1:0] dvd_mag, dsr_mag, prem_d, acc_d;
    logic [WIDTH:0]   shift_d, diff_d;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dsr_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dsr_mag = dsr_neg ? -divisor : divisor;

`ifdef DIV_EARLY_OUT_EN
    assign skip_run = (divisor == '0) || (dsr_mag > dvd_mag);
`else
    assign skip_run = (divisor == '0);
`endif

    // Partial remainder is always below the divisor, so the WIDTH+1-bit
    // difference MSB is a reliable borrow flag.
    always_comb begin
        shift_d = {prem_q, acc_q[WIDTH-1]};
        diff_d  = shift_d - {1'b0, dsr_q};
        prem_d  = diff_d[WIDTH] ? shift_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
        acc_d   = {acc_q[WIDTH-2:0], ~diff_d[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            prem_q     <= '0;
            dsr_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        dbz_q      <= 1'b0;
                        dbz_pend_q <= (divisor == '0);
                        cnt_q      <= CNT_W'(WIDTH);
                        dsr_q      <= dsr_mag;
                        // Skipped ops finish with quotient 0, remainder = raw dividend.
                        prem_q     <= skip_run ? dividend : '0;
                        acc_q      <= skip_run ? '0 : dvd_mag;
                        q_neg_q    <= skip_run ? 1'b0 : (dvd_neg ^ dsr_neg);
                        r_neg_q    <= skip_run ? 1'b0 : dvd_neg;
                        state_q    <= skip_run ? FIN : RUN;
                    end
                end
                RUN: begin
                    prem_q <= prem_d;
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_q <= FIN;
                end
                FIN: begin
                    quot_q  <= q_neg_q ? -acc_q : acc_q;
                    rem_q   <= r_neg_q ? -prem_q : prem_q;
                    dbz_q   <= dbz_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
